// File: rtl/rv_upsizer.sv
// Ready/valid width upsizer: packs Ratio narrow beats (lane 0 first) into one
// wide word, with in_last flushing a partial word and out_keep marking valid lanes.
module rv_upsizer #(
    parameter int DataWidth = 8,
    parameter int Ratio     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DataWidth-1:0]       in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DataWidth*Ratio-1:0] out_data,
    output logic [Ratio-1:0]           out_keep,
    output logic                       out_last
);

    localparam int CntW  = $clog2(Ratio);
    localparam int WordW = DataWidth * Ratio;

    logic [WordW-1:0] acc;
    logic [CntW-1:0]  cnt;
    logic             accept;
    logic             complete;
    logic [WordW-1:0] word_next;
    logic [Ratio-1:0] keep_next;

    // A word may only be taken when the holding register is empty or draining now.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt == CntW'(Ratio - 1)) || in_last);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        word_next = '0;
        keep_next = '0;
        for (int k = 0; k < Ratio; k++) begin
            if (k == int'(cnt)) begin
                word_next[k*DataWidth +: DataWidth] = in_data;
                keep_next[k]                        = 1'b1;
            end else if (k < int'(cnt)) begin
                word_next[k*DataWidth +: DataWidth] = acc[k*DataWidth +: DataWidth];
                keep_next[k]                        = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (complete) begin
                out_data  <= word_next;
                out_keep  <= keep_next;
                out_last  <= in_last;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    for (int k = 0; k < Ratio; k++) begin
                        if (k == int'(cnt)) begin
                            acc[k*DataWidth +: DataWidth] <= in_data;
                        end
                    end
                    cnt <= cnt + CntW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_upsizer.sv
// Self-checking bench for rv_upsizer: directed scenarios plus random traffic,
// scored against a queue-based reference packer.
module tb_rv_upsizer;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int WW = DW * R;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;

    rv_upsizer #(.DataWidth(DW), .Ratio(R)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] data;
        logic [R-1:0]  keep;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] part[$];
    int            total = 0;
    int            bad = 0;
    int            accepted = 0;
    logic          took = 1'b0;
    logic          exp_ov;
    logic          acc_now;
    logic          hold_prev = 1'b0;
    logic [WW-1:0] prev_data;
    logic [R-1:0]  prev_keep;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference packer: collects accepted beats, emits a word on Ratio beats or in_last.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_ov", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_keep", out_keep, 0);
            check("rst_last", out_last, 0);
            check("rst_ir", in_ready, 0);
            exp_q.delete();
            part.delete();
            hold_prev = 1'b0;
            took = 1'b0;
        end else begin
            exp_ov = (exp_q.size() != 0);
            check("ov", out_valid, exp_ov);
            check("ir", in_ready, !exp_ov || out_ready);
            if (exp_ov) begin
                check("data", out_data, exp_q[0].data);
                check("keep", out_keep, exp_q[0].keep);
                check("last", out_last, exp_q[0].last);
            end
            if (hold_prev) begin
                check("stable_ov", out_valid, 1);
                check("stable_data", out_data, prev_data);
                check("stable_keep", out_keep, prev_keep);
                check("stable_last", out_last, prev_last);
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
            acc_now = in_valid && (!exp_ov || out_ready);
            if (exp_ov && out_ready) void'(exp_q.pop_front());
            if (acc_now) begin
                part.push_back(in_data);
                if (part.size() == R || in_last) begin
                    word_t w;
                    w.data = '0;
                    for (int k = 0; k < part.size(); k++)
                        w.data = w.data | (WW'(part[k]) << (k * DW));
                    w.keep = R'((1 << part.size()) - 1);
                    w.last = in_last;
                    exp_q.push_back(w);
                    part.delete();
                end
                accepted++;
            end
            took = acc_now;
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("async_ov", out_valid, 0);
        check("async_data", out_data, 0);
        check("async_ir", in_ready, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("release_ir", in_ready, 1);
    endtask

    task automatic expect_word(input string tag, input logic [WW-1:0] d, input logic [R-1:0] k,
                               input logic l);
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_keep"}, out_keep, k);
        check({tag, "_last"}, out_last, l);
    endtask

    initial begin
        int i;
        int guard;
        int base;
        #2;
        rst = 1'b1;
        #1;
        check("init_ov", out_valid, 0);
        check("init_ir", in_ready, 0);
        do_reset();

        // Full word
        step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
        step(0, 8'h00, 0, 1);
        expect_word("full", 32'h44332211, 4'b1111, 0);

        // Partial flush, then lanes restart at 0
        step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
        step(0, 8'h00, 0, 1);
        expect_word("flush", 32'h0000BBAA, 4'b0011, 1);
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
        step(0, 8'h00, 0, 1);
        expect_word("after_flush", 32'h04030201, 4'b1111, 0);

        // Last on the final lane gives one full word only
        step(1, 8'hC1, 0, 1); step(1, 8'hC2, 0, 1); step(1, 8'hC3, 0, 1); step(1, 8'hC4, 1, 1);
        step(0, 8'h00, 0, 1);
        expect_word("full_last", 32'hC4C3C2C1, 4'b1111, 1);
        step(0, 8'h00, 0, 1);
        check("no_empty_word", out_valid, 0);

        // Backpressure
        step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 0);
        for (int n = 0; n < 5; n++) begin
            step(1, 8'h55, 0, 0);
            check("bp_took", took, 0);
            check("bp_ir", in_ready, 0);
            expect_word("bp", 32'h44332211, 4'b1111, 0);
        end
        step(1, 8'h55, 0, 1);
        check("bp_release_took", took, 1);
        step(1, 8'h66, 0, 1); step(1, 8'h77, 0, 1); step(1, 8'h88, 0, 1);
        step(0, 8'h00, 0, 1);
        expect_word("bp_next", 32'h88776655, 4'b1111, 0);

        // Back-to-back words with continuous ready
        for (int n = 1; n <= 8; n++) begin
            step(1, DW'(n), 0, 1);
            check("b2b_took", took, 1);
            if (n == 5) expect_word("b2b_w0", 32'h04030201, 4'b1111, 0);
        end
        step(0, 8'h00, 0, 1);
        expect_word("b2b_w1", 32'h08070605, 4'b1111, 0);

        // Same beats with out_ready toggling every cycle
        i = 1;
        guard = 0;
        while (i <= 8 && guard < 100) begin
            step(1, DW'(i), 0, guard[0]);
            if (took) i++;
            guard++;
        end
        check("toggle_budget", i, 9);
        repeat (3) step(0, 8'h00, 0, 1);

        // Reset mid-word discards the partial word
        step(1, 8'hAA, 0, 1); step(1, 8'hBB, 0, 1);
        do_reset();
        step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
        step(0, 8'h00, 0, 1);
        expect_word("post_reset", 32'h04030201, 4'b1111, 0);

        // Reset while a word is held drops it
        step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
        step(0, 8'h00, 0, 0);
        check("held_ov", out_valid, 1);
        do_reset();

        // Random traffic
        base = accepted;
        guard = 0;
        while (accepted - base < 2000 && guard < 20000) begin
            step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6);
            guard++;
        end
        check("rand_budget", accepted - base >= 2000, 1);
        repeat (3) step(0, 8'h00, 0, 1);
        check("drain_ov", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
